// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Arbitrates an instruction-fetch port and a data port onto one memory
//   port. Each granted transaction drives the memory strobe for MemLatency
//   cycles, registers MemOutput on the last strobe cycle and answers with a
//   one-cycle valid pulse in the following IDLE cycle. That IDLE cycle also
//   arbitrates, so one transaction completes every MemLatency+1 cycles.
//   Data wins over fetch when both request in the same IDLE cycle.
//
// Parameters
//   DataWidth   data bus width
//   AddrWidth   address width
//   MemLatency  strobe length in cycles (1..4)
//   StarveLimit consecutive data grants tolerated while fetch waits
//
// Ports
//   CLK, RST                 clock, asynchronous active-high reset
//   if_req, if_addr          fetch request (held until if_gnt) and address
//   if_gnt, if_valid         fetch accepted / fetch data valid (pulses)
//   if_rdata                 fetched word
//   dm_req, dm_we            data request (held until dm_gnt), 1 = store
//   dm_addr, dm_wdata        data address and store data
//   dm_gnt, dm_valid         data accepted / load data or store done (pulses)
//   dm_rdata                 load result (unchanged by stores)
//   MemRead, MemWrite        memory strobes
//   MemAddr, MemData         memory address / write data, 0 when idle
//   MemOutput                memory read data
//   busy                     high while a transaction is in ACCESS
//
// Configuration
//   ARB_STARVE_GUARD_EN  when defined, after StarveLimit consecutive data
//                        grants made while fetch waits, the next arbitration
//                        grants fetch. When undefined, data priority is
//                        strict and fetch may starve.
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int unsigned DataWidth   = 16,
  parameter int unsigned AddrWidth   = 16,
  parameter int unsigned MemLatency  = 1,
  parameter int unsigned StarveLimit = 3
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 if_req,
  input  logic [AddrWidth-1:0] if_addr,
  output logic                 if_gnt,
  output logic                 if_valid,
  output logic [DataWidth-1:0] if_rdata,
  input  logic                 dm_req,
  input  logic                 dm_we,
  input  logic [AddrWidth-1:0] dm_addr,
  input  logic [DataWidth-1:0] dm_wdata,
  output logic                 dm_gnt,
  output logic                 dm_valid,
  output logic [DataWidth-1:0] dm_rdata,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic [AddrWidth-1:0] MemAddr,
  output logic [DataWidth-1:0] MemData,
  input  logic [DataWidth-1:0] MemOutput,
  output logic                 busy
);

  localparam int unsigned LatW = (MemLatency > 1) ? $clog2(MemLatency) : 1;
  localparam logic [LatW-1:0] LatLast = LatW'(MemLatency - 1);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACCESS = 1'b1;

  // Elaboration-time guard against unsupported parameter values.
  if (MemLatency < 1 || MemLatency > 4 || StarveLimit < 1) begin : g_bad_param
    $error("mem_port_arbiter: MemLatency must be 1..4 and StarveLimit >= 1");
  end

  logic [0:0]           state_q,    state_d;
  logic                 owner_q,    owner_d;     // 1 = data port owns ACCESS
  logic [LatW-1:0]      lat_cnt_q,  lat_cnt_d;
  logic                 rd_q,       rd_d;
  logic                 wr_q,       wr_d;
  logic [AddrWidth-1:0] addr_q,     addr_d;
  logic [DataWidth-1:0] data_q,     data_d;
  logic                 busy_q,     busy_d;
  logic                 if_gnt_q,   if_gnt_d;
  logic                 dm_gnt_q,   dm_gnt_d;
  logic                 if_valid_q, if_valid_d;
  logic                 dm_valid_q, dm_valid_d;
  logic [DataWidth-1:0] if_rdata_q, if_rdata_d;
  logic [DataWidth-1:0] dm_rdata_q, dm_rdata_d;
  logic                 pick_data;
  logic                 force_fetch_c;

`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned CntW = $clog2(StarveLimit + 1);

  logic [CntW-1:0] starve_q, starve_d;

  // Fetch is forced once data has been granted StarveLimit times in a row
  // while fetch was waiting.
  assign force_fetch_c = if_req & (starve_q >= CntW'(StarveLimit));
`else
  assign force_fetch_c = 1'b0;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    lat_cnt_d  = lat_cnt_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    data_d     = data_q;
    busy_d     = busy_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    if_gnt_d   = 1'b0;
    dm_gnt_d   = 1'b0;
    if_valid_d = 1'b0;
    dm_valid_d = 1'b0;
    pick_data  = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
    starve_d   = starve_q;
`endif

    case (state_q)
      IDLE: begin
        if (if_req || dm_req) begin
          pick_data = dm_req & ~force_fetch_c;
          state_d   = ACCESS;
          owner_d   = pick_data;
          lat_cnt_d = '0;
          busy_d    = 1'b1;
          if (pick_data) begin
            dm_gnt_d = 1'b1;
            rd_d     = ~dm_we;
            wr_d     = dm_we;
            addr_d   = dm_addr;
            data_d   = dm_wdata;
          end else begin
            if_gnt_d = 1'b1;
            rd_d     = 1'b1;
            wr_d     = 1'b0;
            addr_d   = if_addr;
            data_d   = '0;
          end
`ifdef ARB_STARVE_GUARD_EN
          // Only data grants that keep a waiting fetch waiting are counted.
          if (pick_data && if_req) begin
            starve_d = starve_q + CntW'(1);
          end else begin
            starve_d = '0;
          end
`endif
        end
      end

      ACCESS: begin
        if (lat_cnt_q == LatLast) begin
          // Last strobe cycle: capture read data and release the port.
          state_d = IDLE;
          busy_d  = 1'b0;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          addr_d  = '0;
          data_d  = '0;
          if (owner_q) begin
            dm_valid_d = 1'b1;
            if (rd_q) begin
              dm_rdata_d = MemOutput;
            end
          end else begin
            if_valid_d = 1'b1;
            if_rdata_d = MemOutput;
          end
        end else begin
          lat_cnt_d = lat_cnt_q + LatW'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      lat_cnt_q  <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      busy_q     <= 1'b0;
      if_gnt_q   <= 1'b0;
      dm_gnt_q   <= 1'b0;
      if_valid_q <= 1'b0;
      dm_valid_q <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
`ifdef ARB_STARVE_GUARD_EN
      starve_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      lat_cnt_q  <= lat_cnt_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      if_gnt_q   <= if_gnt_d;
      dm_gnt_q   <= dm_gnt_d;
      if_valid_q <= if_valid_d;
      dm_valid_q <= dm_valid_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
`ifdef ARB_STARVE_GUARD_EN
      starve_q   <= starve_d;
`endif
    end
  end

  assign if_gnt   = if_gnt_q;
  assign dm_gnt   = dm_gnt_q;
  assign if_valid = if_valid_q;
  assign dm_valid = dm_valid_q;
  assign if_rdata = if_rdata_q;
  assign dm_rdata = dm_rdata_q;
  assign MemRead  = rd_q;
  assign MemWrite = wr_q;
  assign MemAddr  = addr_q;
  assign MemData  = data_q;
  assign busy     = busy_q;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be: DataWidth, default 16, data bus width; AddrWidth, default 16, address width; MemLatency, default 1 (legal range 1-4), number of cycles the memory strobe is held; StarveLimit, default 3, consecutive data grants allowed while fetch waits.
REQ-002 CLK  input  1  single clock; all state updates on the rising edge.
REQ-003 RST  input  1  asynchronous, active-high reset.
REQ-004 if_req  input  1  instruction-fetch request, held until if_gnt.
REQ-005 if_addr  input  AddrWidth  fetch address, stable while if_req is high.
REQ-006 if_gnt / if_valid  output  1 each  fetch accepted / fetch data valid (1-cycle pulses).
REQ-007 if_rdata  output  DataWidth  fetched word, meaningful only while if_valid is high.
REQ-008 dm_req, dm_we  input  1 each  data request, held until dm_gnt; write when dm_we=1, else load.
REQ-009 dm_addr / dm_wdata  input  AddrWidth / DataWidth  data address and store data.
REQ-010 dm_gnt / dm_valid  output  1 each  data accepted / load data or store completion (1-cycle pulses).
REQ-011 dm_rdata  output  DataWidth  load result, meaningful only while dm_valid is high.
REQ-012 MemRead / MemWrite  output  1 each  memory strobes, mutually exclusive.
REQ-013 MemAddr / MemData  output  AddrWidth / DataWidth  memory address and write data.
REQ-014 MemOutput  input  DataWidth  memory read data, sampled on the last strobe cycle.
REQ-015 busy  output  1  high while a transaction is in ACCESS.

Function
REQ-016 The FSM SHALL have two states: IDLE and ACCESS.
REQ-017 In IDLE with any request pending at a clock edge, the arbiter SHALL select one requester, latch its address, we and wdata, and enter ACCESS.
REQ-018 The selected requester's gnt SHALL be high only in the first ACCESS cycle, one cycle after the sampling edge.
REQ-019 MemAddr, MemData and the strobe SHALL be driven from the latched values for exactly MemLatency cycles in ACCESS; MemRead=~we, MemWrite=we.
REQ-020 At the edge ending the last ACCESS cycle, MemOutput SHALL be registered into rdata and the FSM SHALL return to IDLE.
REQ-021 The owner's valid SHALL pulse in the following IDLE cycle; stores pulse dm_valid with dm_rdata unchanged.
REQ-022 Latency: request sampled at edge k gives gnt in cycle k+1, strobes in cycles k+1..k+MemLatency and valid in cycle k+MemLatency+1.
REQ-023 Throughput: one transaction per MemLatency+1 cycles; the valid IDLE cycle SHALL also arbitrate the next request.
REQ-024 Default priority: data over fetch when both request in the same IDLE cycle.
REQ-025 Requests arriving during ACCESS SHALL be ignored and held; no request is dropped or granted twice.
REQ-026 When no strobe is active, MemAddr and MemData SHALL be 0.
REQ-027 At most one of MemRead or MemWrite, one gnt and one valid SHALL be high in any cycle.

Reset
REQ-028 RST SHALL immediately force IDLE and set all outputs to 0, including rdata registers and the starvation counter.
REQ-029 RST during ACCESS SHALL abort the transaction with no gnt repeat and no valid pulse; requesters re-request after reset.

Configuration
REQ-030 Macro ARB_STARVE_GUARD_EN defined: a counter SHALL count consecutive data grants made while if_req is high; at StarveLimit the next arbitration SHALL grant fetch; the counter SHALL clear on any fetch grant or whenever if_req is low at arbitration.
REQ-031 Macro ARB_STARVE_GUARD_EN undefined: strict data priority with no counter logic, and fetch may starve indefinitely.

Verification
REQ-032 if_req=1, if_addr=0x0004, MemOutput=0x1A2B, MemLatency=1: if_gnt at cycle 1, MemRead at cycle 1 with MemAddr=0x0004, if_valid with if_rdata=0x1A2B at cycle 2.
REQ-033 if_req and dm_req (store, dm_addr=0x0010, dm_wdata=0xBEEF) rise together: dm_gnt first, MemWrite with MemData=0xBEEF, dm_valid, then if_gnt at the next arbitration.
REQ-034 dm_req held high continuously plus if_req=1, StarveLimit=3: with the macro, 3 data grants then 1 fetch grant; without it, no if_gnt in 20 cycles.
REQ-035 MemLatency=3 load: MemRead high for exactly 3 cycles, dm_valid 4 cycles after the sampling edge, and a second request is ignored until IDLE.
REQ-036 RST asserted in the second cycle of a MemLatency=3 access: strobes, busy and gnt drop immediately, no valid pulse, and after release a held request is granted normally.
